// File: rtl/regfile_sb.sv
// Register bank (2R/1W) with a per-register busy scoreboard; reads and busy lookups are combinational, writes/issues land at the edge.
// Never stalls: decode owns the stall decision using busy1/busy2/busy_rd.
module regfile_sb #(
    parameter int XLEN    = 32,
    parameter int NREGS   = 32,
    parameter int AW      = 5,
    parameter bit BYPASS  = 1'b1,
    parameter bit ZERO_X0 = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            regWrite,
    input  logic [AW-1:0]   a1,
    input  logic [AW-1:0]   a2,
    input  logic [AW-1:0]   a3,
    input  logic [XLEN-1:0] wd3,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rd,
    output logic            busy1,
    output logic            busy2,
    output logic            busy_rd,
    output logic [AW:0]     busy_count
);

    // Storage spans the whole address space; entries at or above NREGS are never
    // written, so they stay constant zero and fall out in synthesis.
    localparam int DEPTH = 1 << AW;

    logic [XLEN-1:0]  r_mem [DEPTH];
    logic [DEPTH-1:0] r_busy;
    logic [AW:0]      r_busy_count;

    logic w_we;
    logic w_set;
    logic w_hit1;
    logic w_hit2;
    logic w_inc;
    logic w_dec;

    function automatic logic f_valid(input logic [AW-1:0] a);
        return {1'b0, a} < (AW+1)'(NREGS);
    endfunction

    function automatic logic f_live(input logic [AW-1:0] a);
        return f_valid(a) && !(ZERO_X0 && (a == '0));
    endfunction

    assign w_we   = regWrite && f_live(a3);
    assign w_set  = issue_valid && f_live(issue_rd);
    assign w_hit1 = BYPASS && w_we && (a3 == a1);
    assign w_hit2 = BYPASS && w_we && (a3 == a2);

    // A same-register issue+writeback keeps the bit set, so it is not a decrement.
    assign w_inc = w_set && !r_busy[issue_rd];
    assign w_dec = w_we && r_busy[a3] && !(w_set && (issue_rd == a3));

    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (f_live(a1)) begin
            rd1 = w_hit1 ? wd3 : r_mem[a1];
        end
        if (f_live(a2)) begin
            rd2 = w_hit2 ? wd3 : r_mem[a2];
        end
    end

    assign busy1      = f_valid(a1) && r_busy[a1] && !w_hit1;
    assign busy2      = f_valid(a2) && r_busy[a2] && !w_hit2;
    assign busy_rd    = f_valid(issue_rd) && r_busy[issue_rd];
    assign busy_count = r_busy_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_busy       <= '0;
            r_busy_count <= '0;
        end else begin
            if (w_we) begin
                r_mem[a3]  <= wd3;
                r_busy[a3] <= 1'b0;
            end
            // Placed after the clear so a same-register issue wins.
            if (w_set) begin
                r_busy[issue_rd] <= 1'b1;
            end
            if (w_inc && !w_dec) begin
                r_busy_count <= r_busy_count + (AW+1)'(1);
            end else if (w_dec && !w_inc) begin
                r_busy_count <= r_busy_count - (AW+1)'(1);
            end
        end
    end

endmodule
